mcpu_soc_intctl: RTL

Interrupt controller for the MCPU SoC. It collects up to 16 interrupt request lines from SoC peripherals (UART, I2C, SD, buttons, timers) and prioritises them. It drives the core's `int_pending`/`int_type` inputs and consumes the core's `int_clear` acknowledge. Its registers are programmed through the same word-addressed peripheral bus the data cache uses for MMIO; the block sits beside the other MMIO peripherals, directly upstream of the core's interrupt inputs.

---
 rtl/mcpu_soc_pkg.sv | 19 +
 rtl/mcpu_soc_intctl_prio.sv | 19 +
 rtl/mcpu_soc_intctl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mcpu_soc_pkg.sv
// Shared MCPU SoC definitions: interrupt controller register map, CTRL bit layout
// and FSM state type.
package mcpu_soc_pkg;

  localparam logic [1:0] INTCTL_PENDING = 2'd0;
  localparam logic [1:0] INTCTL_ENABLE  = 2'd1;
  localparam logic [1:0] INTCTL_EDGE    = 2'd2;
  localparam logic [1:0] INTCTL_CTRL    = 2'd3;

  localparam int unsigned CTRL_GIE_BIT  = 0;
  localparam int unsigned CTRL_TYPE_LSB = 4;
  localparam int unsigned CTRL_PEND_BIT = 8;

  typedef enum logic {
    StIdle,
    StOffer
  } intctl_state_e;

endpackage

// File: rtl/mcpu_soc_intctl_prio.sv
// Lowest-index-wins priority encoder for the interrupt controller.
module mcpu_soc_intctl_prio #(
  parameter int unsigned NSRC = 16
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [3:0]      idx
);

  always_comb begin
    valid = |req;
    idx   = 4'd0;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/mcpu_soc_intctl.sv
// MCPU SoC interrupt controller: per-source edge/level capture, MMIO register window
// and a two-state offer/acknowledge handshake towards the core.
module mcpu_soc_intctl
  import mcpu_soc_pkg::*;
#(
  parameter int unsigned NSRC = 16
) (
  input  logic            clkrst_core_clk,
  input  logic            clkrst_core_rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            periph_sel,
  input  logic [1:0]      periph_addr,
  input  logic            periph_re,
  input  logic [3:0]      periph_we,
  input  logic [31:0]     periph_data_in,
  output logic [31:0]     periph_data_out,
  output logic            int_pending,
  output logic [3:0]      int_type,
  input  logic            int_clear
);

  logic [NSRC-1:0] prev_q, latch_q, latch_d;
  logic [NSRC-1:0] enable_q, enable_d, edge_q, edge_d;
  logic            gie_q, gie_d;
  logic [31:0]     dout_q, dout_d, rdata;
  logic [3:0]      int_type_q, int_type_d;
  intctl_state_e   state_q, state_d;

  logic [NSRC-1:0] pending, eligible, rise, wmask, wdata, w1c_clr, ack_clr;
  logic            wr, rd, win_valid, ack;
  logic [3:0]      win_idx;
  logic            unused_data;

  assign unused_data = ^periph_data_in;

  assign wr  = periph_sel & (|periph_we);
  assign rd  = periph_sel & periph_re;
  assign ack = (state_q == StOffer) & int_clear;

  assign rise     = irq_src & ~prev_q;
  assign pending  = (edge_q & latch_q) | (~edge_q & irq_src);
  assign eligible = gie_q ? (pending & enable_q) : '0;

  always_comb begin
    for (int i = 0; i < NSRC; i++) wmask[i] = periph_we[i / 8];
  end
  assign wdata = periph_data_in[NSRC-1:0] & wmask;

  mcpu_soc_intctl_prio #(
    .NSRC (NSRC)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Register writes and W1C decode.
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    gie_d    = gie_q;
    w1c_clr  = '0;
    if (wr) begin
      case (periph_addr)
        INTCTL_PENDING: w1c_clr = wdata;
        INTCTL_ENABLE:  enable_d = (enable_q & ~wmask) | wdata;
        INTCTL_EDGE:    edge_d = (edge_q & ~wmask) | wdata;
        default: begin
          if (periph_we[0]) gie_d = periph_data_in[CTRL_GIE_BIT];
        end
      endcase
    end
  end

  // Acknowledge retires the offered edge source only; a level source stays live.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (ack && (int_type_q == 4'(i)) && edge_q[i]) ack_clr[i] = 1'b1;
    end
  end

  // A fresh rising edge beats any same-cycle clear.
  assign latch_d = (latch_q & ~(w1c_clr | ack_clr)) | rise;

  always_comb begin
    rdata = '0;
    case (periph_addr)
      INTCTL_PENDING: rdata[NSRC-1:0] = pending;
      INTCTL_ENABLE:  rdata[NSRC-1:0] = enable_q;
      INTCTL_EDGE:    rdata[NSRC-1:0] = edge_q;
      default: begin
        rdata[CTRL_GIE_BIT]        = gie_q;
        rdata[CTRL_TYPE_LSB +: 4]  = int_type_q;
        rdata[CTRL_PEND_BIT]       = int_pending;
      end
    endcase
  end

  assign dout_d = rd ? rdata : dout_q;

  always_comb begin
    state_d    = state_q;
    int_type_d = int_type_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d    = StOffer;
          int_type_d = win_idx;
        end
      end
      default: begin
        if (int_clear) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      prev_q     <= '0;
      latch_q    <= '0;
      enable_q   <= '0;
      edge_q     <= '0;
      gie_q      <= 1'b0;
      dout_q     <= '0;
      int_type_q <= 4'd0;
      state_q    <= StIdle;
    end else begin
      prev_q     <= irq_src;
      latch_q    <= latch_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      gie_q      <= gie_d;
      dout_q     <= dout_d;
      int_type_q <= int_type_d;
      state_q    <= state_d;
    end
  end

  assign int_pending     = (state_q == StOffer);
  assign int_type        = int_type_q;
  assign periph_data_out = dout_q;

endmodule
